my_alu_xor_array: RTL and testbench

//  Parametrised N-channel ALU with XOR-reduce, next generation of the dual 8-bit ALU+XOR in the user project.
//  Per channel: one WIDTH-bit op on A/B, plus carry/zero flags; cross-channel XOR of all results and its parity.
//  2-stage pipeline with valid/ready on both sides, full throughput, plus a completed-op counter.

---
 rtl/my_alu_xor_array.sv | 146 ++++++++++++++
 tb/tb_my_alu_xor_array.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/my_alu_xor_array.sv
// ============================================================================
//  Module      : my_alu_xor_array
//  Description : N-channel WIDTH-bit ALU with cross-channel XOR reduce and
//                parity, 2-stage valid/ready pipeline, completed-op counter.
//                Optional saturating ADD/SUB when MY_ALU_SAT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module my_alu_xor_array #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 2,
    parameter int CNT_W    = 16
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_n_i,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CHANNELS*WIDTH-1:0] in_a,
    input  logic [CHANNELS*WIDTH-1:0] in_b,
    input  logic [CHANNELS*3-1:0]     in_op,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CHANNELS*WIDTH-1:0] out_res,
    output logic [CHANNELS-1:0]       out_carry,
    output logic [CHANNELS-1:0]       out_zero,
    output logic [WIDTH-1:0]          out_xor_all,
    output logic                      out_parity,
    output logic [CNT_W-1:0]          ops_count
);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_XNOR = 3'b101;
    localparam logic [2:0] OP_SHL1 = 3'b110;
    localparam logic [2:0] OP_SHR1 = 3'b111;

    logic                      v1;
    logic                      v2;
    logic [CHANNELS*WIDTH-1:0] s1_a;
    logic [CHANNELS*WIDTH-1:0] s1_b;
    logic [CHANNELS*3-1:0]     s1_op;

    logic                      adv1;
    logic                      adv2;
    logic [CHANNELS*WIDTH-1:0] nxt_res;
    logic [CHANNELS-1:0]       nxt_carry;
    logic [CHANNELS-1:0]       nxt_zero;
    logic [WIDTH-1:0]          nxt_xor;

    assign adv2      = !v2 || out_ready;
    assign adv1      = !v1 || adv2;
    assign in_ready  = adv1 && wb_rst_n_i;
    assign out_valid = v2;

    // Returns {carry, result}; carry is bit WIDTH of the widened add/sub.
    function automatic logic [WIDTH:0] alu_op(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic [2:0]       op);
        logic [WIDTH:0] r;
        r = '0;
        case (op)
            OP_ADD:  r = {1'b0, a} + {1'b0, b};
            OP_SUB:  r = {1'b0, a} - {1'b0, b};
            OP_AND:  r = {1'b0, a & b};
            OP_OR:   r = {1'b0, a | b};
            OP_XOR:  r = {1'b0, a ^ b};
            OP_XNOR: r = {1'b0, ~(a ^ b)};
            OP_SHL1: r = {a[WIDTH-1], a[WIDTH-2:0], 1'b0};
            OP_SHR1: r = {a[0], 1'b0, a[WIDTH-1:1]};
            default: r = '0;
        endcase
`ifdef MY_ALU_SAT_EN
        if (op == OP_ADD && r[WIDTH]) begin
            r[WIDTH-1:0] = '1;
        end else if (op == OP_SUB && r[WIDTH]) begin
            r[WIDTH-1:0] = '0;
        end
`endif
        return r;
    endfunction

    generate
        for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
            logic [WIDTH:0] ch_out;
            assign ch_out = alu_op(s1_a[c*WIDTH +: WIDTH],
                                   s1_b[c*WIDTH +: WIDTH],
                                   s1_op[c*3 +: 3]);
            assign nxt_res[c*WIDTH +: WIDTH] = ch_out[WIDTH-1:0];
            assign nxt_carry[c]              = ch_out[WIDTH];
            assign nxt_zero[c]               = (ch_out[WIDTH-1:0] == '0);
        end
    endgenerate

    always_comb begin
        nxt_xor = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            nxt_xor = nxt_xor ^ nxt_res[c*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            v1          <= 1'b0;
            v2          <= 1'b0;
            s1_a        <= '0;
            s1_b        <= '0;
            s1_op       <= '0;
            out_res     <= '0;
            out_carry   <= '0;
            out_zero    <= '0;
            out_xor_all <= '0;
            out_parity  <= 1'b0;
            ops_count   <= '0;
        end else begin
            if (adv1) begin
                v1 <= in_valid;
                if (in_valid) begin
                    s1_a  <= in_a;
                    s1_b  <= in_b;
                    s1_op <= in_op;
                end
            end
            // Stage 2 also absorbs a stage-1 bundle when no new input arrives.
            if (adv2) begin
                v2 <= v1;
                if (v1) begin
                    out_res     <= nxt_res;
                    out_carry   <= nxt_carry;
                    out_zero    <= nxt_zero;
                    out_xor_all <= nxt_xor;
                    out_parity  <= ^nxt_xor;
                end
            end
            if (v2 && out_ready) begin
                ops_count <= ops_count + CNT_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_my_alu_xor_array.sv
// Directed, table-driven bench for my_alu_xor_array (default build and MY_ALU_SAT_EN build).
`default_nettype none

module tb_my_alu_xor_array;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic [5:0]  in_op = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_res;
    logic [1:0]  out_carry;
    logic [1:0]  out_zero;
    logic [7:0]  out_xor_all;
    logic        out_parity;
    logic [15:0] ops_count;

    logic        in_valid2 = 1'b0;
    logic        in_ready2;
    logic [63:0] in_a2 = '0;
    logic [63:0] in_b2 = '0;
    logic [11:0] in_op2 = '0;
    logic        out_valid2;
    logic        out_ready2 = 1'b0;
    logic [63:0] out_res2;
    logic [3:0]  out_carry2;
    logic [3:0]  out_zero2;
    logic [15:0] out_xor2;
    logic        out_parity2;
    logic [3:0]  ops_count2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    my_alu_xor_array dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_res(out_res), .out_carry(out_carry), .out_zero(out_zero),
        .out_xor_all(out_xor_all), .out_parity(out_parity),
        .ops_count(ops_count)
    );

    my_alu_xor_array #(.WIDTH(16), .CHANNELS(4), .CNT_W(4)) dut2 (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .in_valid(in_valid2), .in_ready(in_ready2),
        .in_a(in_a2), .in_b(in_b2), .in_op(in_op2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .out_res(out_res2), .out_carry(out_carry2), .out_zero(out_zero2),
        .out_xor_all(out_xor2), .out_parity(out_parity2),
        .ops_count(ops_count2)
    );

    typedef struct {
        logic [7:0] a0; logic [7:0] b0; logic [2:0] op0;
        logic [7:0] a1; logic [7:0] b1; logic [2:0] op1;
        logic [7:0] r0; logic [7:0] r1;
        logic [1:0] cy; logic [1:0] z;
        logic [7:0] xa; logic       par;
    } vec_t;

    vec_t vt[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!out_valid && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("valid_timeout", {63'd0, out_valid}, 64'd1);
    endtask

    task automatic apply_vec(input vec_t v);
        @(negedge clk);
        in_a      = {v.a1, v.a0};
        in_b      = {v.b1, v.b0};
        in_op     = {v.op1, v.op0};
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("vec_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("vec_not_early", {63'd0, out_valid}, 64'd0);
        wait_valid();
        chk("vec_res",    {48'd0, out_res},     {48'd0, v.r1, v.r0});
        chk("vec_carry",  {62'd0, out_carry},   {62'd0, v.cy});
        chk("vec_zero",   {62'd0, out_zero},    {62'd0, v.z});
        chk("vec_xor",    {56'd0, out_xor_all}, {56'd0, v.xa});
        chk("vec_parity", {63'd0, out_parity},  {63'd0, v.par});
        @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] base;
        logic [15:0] prev_res;
        bit          prev_stall;
        bit          acc;
        int          sent;
        int          rcv;
        int          n;

`ifdef MY_ALU_SAT_EN
        vt[0] = '{8'hF0, 8'h20, 3'd0, 8'h0F, 8'hFF, 3'd4, 8'hFF, 8'hF0, 2'b01, 2'b00, 8'h0F, 1'b0};
        vt[1] = '{8'h05, 8'h07, 3'd1, 8'h3C, 8'h0F, 3'd2, 8'h00, 8'h0C, 2'b01, 2'b01, 8'h0C, 1'b0};
        vt[4] = '{8'hFF, 8'h01, 3'd0, 8'h10, 8'h01, 3'd1, 8'hFF, 8'h0F, 2'b01, 2'b00, 8'hF0, 1'b0};
`else
        vt[0] = '{8'hF0, 8'h20, 3'd0, 8'h0F, 8'hFF, 3'd4, 8'h10, 8'hF0, 2'b01, 2'b00, 8'hE0, 1'b1};
        vt[1] = '{8'h05, 8'h07, 3'd1, 8'h3C, 8'h0F, 3'd2, 8'hFE, 8'h0C, 2'b01, 2'b00, 8'hF2, 1'b1};
        vt[4] = '{8'hFF, 8'h01, 3'd0, 8'h10, 8'h01, 3'd1, 8'h00, 8'h0F, 2'b01, 2'b01, 8'h0F, 1'b0};
`endif
        vt[2] = '{8'h50, 8'h0A, 3'd3, 8'hA5, 8'h5A, 3'd5, 8'h5A, 8'h00, 2'b00, 2'b10, 8'h5A, 1'b0};
        vt[3] = '{8'h81, 8'h00, 3'd6, 8'h81, 8'h00, 3'd7, 8'h02, 8'h40, 2'b11, 2'b00, 8'h42, 1'b0};
        vt[5] = '{8'hAA, 8'h55, 3'd2, 8'h12, 8'h34, 3'd0, 8'h00, 8'h46, 2'b00, 2'b01, 8'h46, 1'b1};
        vt[6] = '{8'h07, 8'h05, 3'd1, 8'h77, 8'h77, 3'd4, 8'h02, 8'h00, 2'b00, 2'b10, 8'h02, 1'b1};

        // Reset state
        repeat (3) @(negedge clk);
        in_valid = 1'b1;
        #1;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_res", {48'd0, out_res}, 64'd0);
        chk("rst_count", {48'd0, ops_count}, 64'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

        for (int i = 0; i < 7; i++) apply_vec(vt[i]);
        @(negedge clk);
        chk("count_after_vecs", {48'd0, ops_count}, 64'd7);

        // Streaming with out_ready toggling 1,0,1,0...
        base       = ops_count;
        sent       = 0;
        rcv        = 0;
        prev_stall = 1'b0;
        prev_res   = '0;
        for (int cyc = 0; cyc < 80 && rcv < 8; cyc++) begin
            @(negedge clk);
            if (prev_stall) begin
                chk("stream_hold_valid", {63'd0, out_valid}, 64'd1);
                chk("stream_hold_res", {48'd0, out_res}, {48'd0, prev_res});
            end
            out_ready = (cyc % 2 == 0);
            in_valid  = (sent < 8);
            in_a      = {8'(sent), 8'(sent * 7)};
            in_b      = {8'h55, 8'(sent * 5)};
            in_op     = {3'd4, 3'd0};
            #1;
            acc = in_valid && in_ready;
            if (out_valid && out_ready) begin
                chk("stream_res", {48'd0, out_res}, {48'd0, 8'(rcv) ^ 8'h55, 8'(rcv * 12)});
                rcv++;
            end
            prev_stall = out_valid && !out_ready;
            prev_res   = out_res;
            @(posedge clk);
            if (acc) sent++;
        end
        in_valid = 1'b0;
        chk("stream_received", 64'(rcv), 64'd8);
        @(negedge clk);
        chk("stream_count", {48'd0, ops_count}, {48'd0, base + 16'd8});

        // Backpressure: two bundles fill the pipe, third waits for out_ready
        @(negedge clk);
        out_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
            if (j > 0) @(negedge clk);
            n        = (j < 2) ? j : 2;
            in_valid = 1'b1;
            in_a     = {8'hFF, 8'(n + 1)};
            in_b     = {8'(n), 8'h10};
            in_op    = {3'd2, 3'd3};
            #1;
            chk("bp_in_ready", {63'd0, in_ready}, (j < 2) ? 64'd1 : 64'd0);
            @(posedge clk);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", {63'd0, in_ready}, 64'd1);
        chk("bp_res0", {47'd0, out_valid, out_res}, {47'd0, 1'b1, 8'h00, 8'h11});
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_res1", {47'd0, out_valid, out_res}, {47'd0, 1'b1, 8'h01, 8'h12});
        @(posedge clk);
        @(negedge clk);
        chk("bp_res2", {47'd0, out_valid, out_res}, {47'd0, 1'b1, 8'h02, 8'h13});
        @(posedge clk);

        // Reset one cycle after an accept
        @(negedge clk);
        in_a     = {vt[3].a1, vt[3].a0};
        in_b     = {vt[3].b1, vt[3].b0};
        in_op    = {vt[3].op1, vt[3].op0};
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("mid_rst_outs", {31'd0, out_valid, out_res, out_carry, out_zero, out_xor_all, out_parity},
            64'd0);
        chk("mid_rst_count", {48'd0, ops_count}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("after_rst_quiet", {63'd0, out_valid}, 64'd0);
            @(negedge clk);
        end
        chk("after_rst_in_ready", {63'd0, in_ready}, 64'd1);
        apply_vec(vt[5]);
        @(negedge clk);
        chk("after_rst_count", {48'd0, ops_count}, 64'd1);

        // Wide instance: SHL1 0x8001 on four 16-bit channels, 4-bit counter wrap
        @(negedge clk);
        in_a2      = {4{16'h8001}};
        in_b2      = '0;
        in_op2     = {4{3'd6}};
        in_valid2  = 1'b1;
        out_ready2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid2 = 1'b0;
        n = 0;
        while (!out_valid2 && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("w_valid", {63'd0, out_valid2}, 64'd1);
        chk("w_res", out_res2, 64'h0002_0002_0002_0002);
        chk("w_carry", {60'd0, out_carry2}, 64'hF);
        chk("w_zero", {60'd0, out_zero2}, 64'd0);
        chk("w_xor_par", {47'd0, out_xor2, out_parity2}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        in_valid2 = 1'b1;
        repeat (16) @(posedge clk);
        @(negedge clk);
        in_valid2 = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("w_count_wrap", {60'd0, ops_count2}, 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
